// File: rtl/decoder_scan_seq_if.sv
// Control/status bundle for decoder_scan_seq.
// The master drives the select controls and the slave returns the decoded lines.
interface decoder_scan_seq_if #(
    parameter int SEL_W = 3,
    parameter int DIV_W = 8
);
    localparam int OUT_W = 2 ** SEL_W;

    logic             enab;
    logic [1:0]       mode;
    logic [SEL_W-1:0] sel_in;
    logic             sel_vld;
    logic [DIV_W-1:0] period;
    logic [OUT_W-1:0] out;
    logic [SEL_W-1:0] cur_sel;
    logic             wrap;
    logic             done;

    modport master (
        output enab, mode, sel_in, sel_vld, period,
        input  out, cur_sel, wrap, done
    );

    modport slave (
        input  enab, mode, sel_in, sel_vld, period,
        output out, cur_sel, wrap, done
    );
endinterface

// File: rtl/decoder_scan_seq.sv
// Registered one-hot decoder with direct-load, free-running scan and single-pass scan modes.
// state   | meaning
// OFF     | output forced low, select and dwell counter hold
// DIRECT  | select changes only on sel_vld
// SCAN    | select advances every period+1 cycles, wraps forever
// SHOT    | select advances up to the last line, then goes to DONE
// DONE    | single pass complete, output low until mode leaves 11
module decoder_scan_seq #(
    parameter int SEL_W = 3,
    parameter int DIV_W = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    decoder_scan_seq_if.slave    bus
);
    localparam int OUT_W = 2 ** SEL_W;

    typedef enum logic [2:0] {
        ST_OFF,
        ST_DIRECT,
        ST_SCAN,
        ST_SHOT,
        ST_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic [SEL_W-1:0] cur_sel_q, cur_sel_d;
    logic [OUT_W-1:0] out_q, out_d;
    logic             wrap_q, wrap_d;
    logic             done_q, done_d;

    state_t tgt;
    logic   mode_chg;
    logic   tick;
    logic   last;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_OFF;
            cnt_q     <= '0;
            cur_sel_q <= '0;
            out_q     <= '0;
            wrap_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            cur_sel_q <= cur_sel_d;
            out_q     <= out_d;
            wrap_q    <= wrap_d;
            done_q    <= done_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        cur_sel_d = cur_sel_q;
        wrap_d    = 1'b0;
        tgt       = ST_OFF;

        case (bus.mode)
            2'b00:   tgt = ST_OFF;
            2'b01:   tgt = ST_DIRECT;
            2'b10:   tgt = ST_SCAN;
            default: tgt = (state_q == ST_SHOT || state_q == ST_DONE) ? state_q : ST_SHOT;
        endcase

        mode_chg = (tgt != state_q);
        // >= rather than == so lowering period below the running count cannot stall a full counter wrap
        tick     = (cnt_q >= bus.period);
        last     = (cur_sel_q == {SEL_W{1'b1}});

        if (mode_chg) begin
            state_d = tgt;
            cnt_d   = '0;
            if (bus.sel_vld && tgt != ST_OFF)
                cur_sel_d = bus.sel_in;
        end else begin
            case (state_q)
                ST_DIRECT: begin
                    cnt_d = '0;
                    if (bus.sel_vld)
                        cur_sel_d = bus.sel_in;
                end
                ST_SCAN, ST_SHOT: begin
                    if (bus.sel_vld) begin
                        cur_sel_d = bus.sel_in;
                        cnt_d     = '0;
                    end else if (tick) begin
                        cnt_d = '0;
                        if (state_q == ST_SHOT && last) begin
                            state_d = ST_DONE;
                        end else begin
                            cur_sel_d = cur_sel_q + 1'b1;
                            wrap_d    = (state_q == ST_SCAN) && last;
                        end
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                default: ;
            endcase
        end

        done_d = (state_d == ST_DONE);
        if (bus.enab && (state_d == ST_DIRECT || state_d == ST_SCAN || state_d == ST_SHOT))
            out_d = OUT_W'(1) << cur_sel_d;
        else
            out_d = '0;
    end

    assign bus.out     = out_q;
    assign bus.cur_sel = cur_sel_q;
    assign bus.wrap    = wrap_q;
    assign bus.done    = done_q;
endmodule

// File: tb/tb_decoder_scan_seq.sv
// Directed, table-driven bench for decoder_scan_seq (SEL_W=3, DIV_W=8).
module tb_decoder_scan_seq;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_pass = 0;
    int   n_total = 0;

    always #5 clk = ~clk;

    decoder_scan_seq_if #(.SEL_W(3), .DIV_W(8)) bus ();

    decoder_scan_seq #(.SEL_W(3), .DIV_W(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic       enab;
        logic [1:0] mode;
        logic [2:0] sel_in;
        logic       sel_vld;
        logic [7:0] period;
        logic [7:0] exp_out;
        logic [2:0] exp_sel;
        logic       exp_wrap;
        logic       exp_done;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic e, input logic [1:0] m, input logic [2:0] si, input logic sv,
                       input logic [7:0] p, input logic [7:0] eo, input logic [2:0] es,
                       input logic ew, input logic ed);
        vec_t v;
        v.enab = e; v.mode = m; v.sel_in = si; v.sel_vld = sv; v.period = p;
        v.exp_out = eo; v.exp_sel = es; v.exp_wrap = ew; v.exp_done = ed;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic [7:0] eo, input logic [2:0] es,
                         input logic ew, input logic ed);
        n_total += 4;
        if (bus.out === eo) n_pass++;
        else $display("FAIL %s out: got %h want %h", name, bus.out, eo);
        if (bus.cur_sel === es) n_pass++;
        else $display("FAIL %s cur_sel: got %0d want %0d", name, bus.cur_sel, es);
        if (bus.wrap === ew) n_pass++;
        else $display("FAIL %s wrap: got %b want %b", name, bus.wrap, ew);
        if (bus.done === ed) n_pass++;
        else $display("FAIL %s done: got %b want %b", name, bus.done, ed);
    endtask

    task automatic step(input string name, input logic e, input logic [1:0] m, input logic [2:0] si,
                        input logic sv, input logic [7:0] p, input logic [7:0] eo,
                        input logic [2:0] es, input logic ew, input logic ed);
        @(negedge clk);
        bus.enab = e; bus.mode = m; bus.sel_in = si; bus.sel_vld = sv; bus.period = p;
        @(posedge clk);
        #1;
        check(name, eo, es, ew, ed);
    endtask

    initial begin
        bus.enab = 1'b0; bus.mode = 2'b00; bus.sel_in = '0; bus.sel_vld = 1'b0; bus.period = '0;

        //  en mode  sel vld per | out    sel w d
        add(1, 2'b00, 5, 1, 0,   8'h00, 0, 0, 0);  // OFF ignores sel_vld
        add(1, 2'b01, 0, 0, 0,   8'h01, 0, 0, 0);
        add(1, 2'b01, 5, 1, 0,   8'h20, 5, 0, 0);
        add(1, 2'b01, 2, 0, 0,   8'h20, 5, 0, 0);
        add(0, 2'b01, 0, 0, 0,   8'h00, 5, 0, 0);
        add(1, 2'b01, 6, 1, 0,   8'h40, 6, 0, 0);
        add(1, 2'b10, 0, 0, 2,   8'h40, 6, 0, 0);  // SCAN period=2
        add(1, 2'b10, 0, 0, 2,   8'h40, 6, 0, 0);
        add(1, 2'b10, 0, 0, 2,   8'h40, 6, 0, 0);
        add(1, 2'b10, 0, 0, 2,   8'h80, 7, 0, 0);
        add(1, 2'b10, 0, 0, 2,   8'h80, 7, 0, 0);
        add(1, 2'b10, 0, 0, 2,   8'h80, 7, 0, 0);
        add(1, 2'b10, 0, 0, 2,   8'h01, 0, 1, 0);
        add(1, 2'b10, 0, 0, 2,   8'h01, 0, 0, 0);
        add(1, 2'b10, 0, 0, 0,   8'h02, 1, 0, 0);  // period=0
        add(1, 2'b10, 3, 1, 0,   8'h08, 3, 0, 0);  // sel_vld beats tick
        add(1, 2'b10, 0, 0, 0,   8'h10, 4, 0, 0);
        add(1, 2'b10, 0, 0, 0,   8'h20, 5, 0, 0);
        add(1, 2'b10, 0, 0, 0,   8'h40, 6, 0, 0);
        add(1, 2'b10, 0, 0, 0,   8'h80, 7, 0, 0);
        add(1, 2'b10, 0, 0, 0,   8'h01, 0, 1, 0);
        add(0, 2'b10, 0, 0, 0,   8'h00, 1, 0, 0);  // enab=0 gates only out
        add(0, 2'b10, 0, 0, 0,   8'h00, 2, 0, 0);
        add(1, 2'b01, 0, 0, 0,   8'h04, 2, 0, 0);
        add(1, 2'b01, 5, 1, 0,   8'h20, 5, 0, 0);
        add(1, 2'b11, 0, 0, 0,   8'h20, 5, 0, 0);  // ONESHOT from 5
        add(1, 2'b11, 0, 0, 0,   8'h40, 6, 0, 0);
        add(1, 2'b11, 0, 0, 0,   8'h80, 7, 0, 0);
        add(1, 2'b11, 0, 0, 0,   8'h00, 7, 0, 1);
        add(1, 2'b11, 0, 0, 0,   8'h00, 7, 0, 1);
        add(1, 2'b11, 2, 1, 0,   8'h00, 7, 0, 1);  // DONE ignores sel_vld
        add(1, 2'b01, 0, 0, 0,   8'h80, 7, 0, 0);
        add(1, 2'b00, 0, 0, 0,   8'h00, 7, 0, 0);

        repeat (2) @(posedge clk);
        #1;
        check("reset", 8'h00, 3'd0, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (vecs[i])
            step($sformatf("vec%0d", i), vecs[i].enab, vecs[i].mode, vecs[i].sel_in, vecs[i].sel_vld,
                 vecs[i].period, vecs[i].exp_out, vecs[i].exp_sel, vecs[i].exp_wrap, vecs[i].exp_done);

        // period lowered 7 -> 1 while the dwell count sits at 5
        step("lower_enter", 1, 2'b10, 0, 0, 8'd7, 8'h80, 7, 0, 0);
        for (int k = 0; k < 5; k++)
            step($sformatf("lower_cnt%0d", k + 1), 1, 2'b10, 0, 0, 8'd7, 8'h80, 7, 0, 0);
        step("lower_tick",  1, 2'b10, 0, 0, 8'd1, 8'h01, 0, 1, 0);
        step("lower_hold0", 1, 2'b10, 0, 0, 8'd1, 8'h01, 0, 0, 0);
        step("lower_adv1",  1, 2'b10, 0, 0, 8'd1, 8'h02, 1, 0, 0);
        step("lower_hold1", 1, 2'b10, 0, 0, 8'd1, 8'h02, 1, 0, 0);
        step("lower_adv2",  1, 2'b10, 0, 0, 8'd1, 8'h04, 2, 0, 0);

        // asynchronous reset in the middle of a scan showing out=8'h10
        step("pre_rst_dir",  1, 2'b01, 0, 0, 8'd0, 8'h04, 2, 0, 0);
        step("pre_rst_load", 1, 2'b01, 4, 1, 8'd0, 8'h10, 4, 0, 0);
        step("pre_rst_scan", 1, 2'b10, 0, 0, 8'd7, 8'h10, 4, 0, 0);
        step("pre_rst_cnt",  1, 2'b10, 0, 0, 8'd7, 8'h10, 4, 0, 0);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst", 8'h00, 3'd0, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        step("post_rst_scan", 1, 2'b10, 0, 0, 8'd7, 8'h01, 0, 0, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
